// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state definitions shared by the sequential ALU
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one partial product per cycle
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod
);

  localparam int CNT_W = $clog2(WIDTH);

  logic             busy_q,   busy_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] acc_next;

  // The last step is folded into prod combinationally so the product is ready on the done cycle.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign prod     = acc_next;

  // Next-state for the shift-add datapath: load on start, otherwise step while busy.
  always_comb begin
    busy_d   = busy_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start) begin
      busy_d   = 1'b1;
      mcand_d  = a;
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) begin
        busy_d = 1'b0;
      end
    end
  end

  // Datapath registers; reset discards any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - handshaked registered ALU with iterative multiply and status flags
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             neg,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
  logic             neg_q, neg_d, illegal_q, illegal_d;

  logic             accept, is_mul, mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res, ld_res;
  logic             alu_c, alu_v, alu_ill, ld_c, ld_v, ld_ill;

  assign in_ready = !rst && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op == OP_MUL) && (MUL_EN != 0);
  assign shamt    = b[SHAMT_W-1:0];
  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (accept && is_mul),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // Single-cycle operations; the extra bit of sum/diff is carry-out or borrow.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: alu_res = a << shamt;
      OP_SRL: alu_res = a >> shamt;
      OP_SRA: alu_res = $unsigned($signed(a) >>> shamt);
      OP_MUL: alu_ill = (MUL_EN == 0);
      default: alu_ill = 1'b1;
    endcase
  end

  // Value to load into the output register: multiplier product when finishing MUL, else ALU.
  always_comb begin
    ld_res = alu_res;
    ld_c   = alu_c;
    ld_v   = alu_v;
    ld_ill = alu_ill;
    if (state_q == ST_MUL) begin
      ld_res = mul_prod;
      ld_c   = 1'b0;
      ld_v   = 1'b0;
      ld_ill = 1'b0;
    end
  end

  // FSM next state and output-register next values; defaults hold everything.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    neg_d       = neg_q;
    illegal_d   = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && is_mul) begin
          state_d     = ST_MUL;
          out_valid_d = 1'b0;
        end else if (accept) begin
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d     = ST_HOLD;
          out_valid_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_q == ST_IDLE && accept && !is_mul) || (state_q == ST_MUL && mul_done)) begin
      result_d  = ld_res;
      zero_d    = (ld_res == '0);
      carry_d   = ld_c;
      ovf_d     = ld_v;
      neg_d     = ld_res[WIDTH-1];
      illegal_d = ld_ill;
    end
  end

  // State and output registers; reset clears everything including flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      neg_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      neg_q       <= neg_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign neg       = neg_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - self-checking bench for alu_seq_unit with reference model
module tb_alu_seq_unit;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  op;
  logic        zero, carry, ovf, neg, illegal;

  logic        in_valid2, in_ready2, out_valid2, out_ready2;
  logic [7:0]  a2, b2, result2;
  logic [3:0]  op2;
  logic        zero2, carry2, ovf2, neg2, illegal2;

  logic [36:0] obs;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(32), .MUL_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .ovf(ovf), .neg(neg), .illegal(illegal)
  );

  alu_seq_unit #(.WIDTH(8), .MUL_EN(0)) dut_nomul (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .op(op2), .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .zero(zero2), .carry(carry2), .ovf(ovf2), .neg(neg2), .illegal(illegal2)
  );

  assign obs = {result, zero, carry, ovf, neg, illegal};

  function automatic logic [36:0] pk(input logic [31:0] r, input logic z, c, v, n, il);
    return {r, z, c, v, n, il};
  endfunction

  // Reference: plain integer arithmetic on the opcode meanings.
  function automatic logic [36:0] ref_alu(input logic [3:0] o, input logic [31:0] x, y);
    longint sx, sy, s;
    logic [31:0] r;
    logic [4:0] sh;
    logic c, v, il;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = y[4:0];
    r = 0; c = 0; v = 0; il = 0;
    case (o)
      4'd0: r = x & y;
      4'd1: r = x | y;
      4'd3: r = x ^ y;
      4'd2: begin
        r = x + y;
        c = (64'(x) + 64'(y)) > 64'hFFFF_FFFF;
        s = sx + sy;
        v = (s > SMAX) || (s < SMIN);
      end
      4'd4: begin
        r = x - y;
        c = x < y;
        s = sx - sy;
        v = (s > SMAX) || (s < SMIN);
      end
      4'd5: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd6: r = x << sh;
      4'd7: r = x >> sh;
      4'd8: r = 32'(sx >>> sh);
      4'd9: r = 32'(64'(x) * 64'(y));
      default: il = 1;
    endcase
    return pk(r, r == 0, c, v, r[31], il);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present one op, wait for its result, check latency, model value and hold stability.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, y, input int hold,
                       output logic [36:0] got);
    int n, irv, unstable;
    logic [36:0] exp;
    exp = ref_alu(o, x, y);
    @(negedge clk);
    in_valid = 1; op = o; a = x; b = y; out_ready = 1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("in_ready_before_issue", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0; a = $urandom; b = $urandom; op = 4'($urandom);
    if (hold > 0) out_ready = 0;
    n = 0; irv = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      if (in_ready) irv++;
      @(negedge clk); n++;
    end
    chk($sformatf("latency_op%0d", o), n, (o == 4'd9) ? 32 : 0);
    if (o == 4'd9) chk("in_ready_low_during_mul", irv, 0);
    chk($sformatf("outputs_op%0d_%h_%h", o, x, y), obs, exp);
    got = obs;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (obs !== exp || !out_valid || in_ready) unstable++;
    end
    if (hold > 0) begin
      chk("held_under_backpressure", unstable, 0);
      out_ready = 1;
    end
  endtask

  initial begin
    logic [36:0] got;
    logic [31:0] ra, rb;
    logic [3:0]  ro;
    logic [31:0] expect_sum;
    int cnt;

    rst = 1; in_valid = 0; out_ready = 0; a = 0; b = 0; op = 0;
    in_valid2 = 0; out_ready2 = 1; a2 = 0; b2 = 0; op2 = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {out_valid, obs}, 38'd0);
    chk("reset_in_ready_low", in_ready, 0);
    rst = 0; #1;
    chk("in_ready_after_reset", in_ready, 1);

    // alu32 regression and signed edges
    issue(4'd0, 32'hF0F0F0F0, 32'h0F0F0F0F, 0, got); chk("and_const", got, pk(32'h0, 1, 0, 0, 0, 0));
    issue(4'd1, 32'hF0000000, 32'h0000FFFF, 0, got); chk("or_const", got, pk(32'hF000FFFF, 0, 0, 0, 1, 0));
    issue(4'd2, 32'd25, 32'd17, 0, got);             chk("add_const", got, pk(32'd42, 0, 0, 0, 0, 0));
    issue(4'd2, 32'hFFFFFFFF, 32'd1, 0, got);        chk("add_wrap", got, pk(32'h0, 1, 1, 0, 0, 0));
    issue(4'd2, 32'h7FFFFFFF, 32'd1, 0, got);        chk("add_ovf", got, pk(32'h80000000, 0, 0, 1, 1, 0));
    issue(4'd4, 32'd0, 32'd1, 0, got);               chk("sub_borrow", got, pk(32'hFFFFFFFF, 0, 1, 0, 1, 0));
    issue(4'd5, 32'hFFFFFFFF, 32'd1, 0, got);        chk("slt_signed", got, pk(32'd1, 0, 0, 0, 0, 0));
    issue(4'd8, 32'h80000000, 32'd24, 0, got);       chk("sra", got, pk(32'hFFFFFF80, 0, 0, 0, 1, 0));
    issue(4'd6, 32'd1, 32'h21, 0, got);              chk("sll_mask", got, pk(32'd2, 0, 0, 0, 0, 0));
    issue(4'd9, 32'h10000, 32'h30005, 0, got);       chk("mul_wrap", got, pk(32'h50000, 0, 0, 0, 0, 0));
    issue(4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, got); chk("illegal_op", got, pk(32'h0, 1, 0, 0, 0, 1));

    // MUL disabled build: illegal, one-cycle latency
    @(negedge clk);
    in_valid2 = 1; op2 = 4'd9; a2 = 8'd3; b2 = 8'd5; #1;
    chk("nomul_in_ready", in_ready2, 1);
    @(posedge clk); #1; in_valid2 = 0;
    @(negedge clk);
    chk("nomul_result", {out_valid2, result2, zero2, carry2, ovf2, neg2, illegal2}, {1'b1, 8'h00, 5'b10001});

    // Back-pressure on ADD 3,4, ignored input, then drain+accept and streaming
    @(negedge clk);
    in_valid = 1; op = 4'd2; a = 32'd3; b = 32'd4; out_ready = 0; #1;
    chk("bp_in_ready", in_ready, 1);
    @(posedge clk); #1; a = 32'd100; b = 32'd100;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid || result !== 32'd7 || in_ready) cnt++;
    end
    chk("bp_hold_7", cnt, 0);
    @(negedge clk);
    out_ready = 1; a = 32'd9; b = 32'd9; #1;
    chk("bp_drain_accept", in_ready, 1);
    @(negedge clk);
    expect_sum = 32'd18;
    for (int i = 0; i < 6; i++) begin
      chk("stream_out", {out_valid, result}, {1'b1, expect_sum});
      chk("stream_ready", in_ready, 1);
      a = 32'(i); b = 32'd10; expect_sum = 32'(i) + 32'd10;
      @(negedge clk);
    end
    chk("stream_last", {out_valid, result}, {1'b1, expect_sum});
    in_valid = 0;
    @(negedge clk);
    chk("stream_drained", out_valid, 0);

    // Reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1; op = 4'd9; a = 32'h1234; b = 32'h5678;
    @(posedge clk); #1; in_valid = 0;
    repeat (9) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midmul_reset_outputs", {out_valid, obs}, 38'd0);
    chk("midmul_reset_in_ready", in_ready, 0);
    rst = 0; #1;
    chk("midmul_release_in_ready", in_ready, 1);
    issue(4'd2, 32'd2, 32'd2, 0, got); chk("post_reset_add", got, pk(32'd4, 0, 0, 0, 0, 0));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("no_stale_mul", cnt, 0);

    // Randomized ops against the model, with occasional back-pressure
    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra = 32'h7FFFFFFF;
        1: rb = 32'h80000000;
        default: ;
      endcase
      issue(ro, ra, rb, int'($urandom_range(0, 3)), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
